// File: rtl/seq_shifter_if.sv
// Handshake and data bundle between the datapath controller and seq_shifter.
// The controller drives the request side; the shifter returns status and result.
interface seq_shifter_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             start;
  logic             abort;
  logic [1:0]       op;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] a;
  logic             ready;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] result;

  modport master (
    output start, abort, op, shamt, a,
    input  ready, busy, valid, result
  );

  modport slave (
    input  start, abort, op, shamt, a,
    output ready, busy, valid, result
  );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROR by a runtime amount, at most STEP
// bits per clock, with a start/busy/valid handshake beside the ALU.
module seq_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_shifter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // One bit wider than rem so that STEP==WIDTH is representable.
  localparam logic [SHW:0] STEP_K = (SHW+1)'(STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [1:0]       op_q, op_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [SHW:0]     k;

  // Shift v by k bits (k < WIDTH) according to the latched operation.
  function automatic logic [WIDTH-1:0] shift_by(input logic [1:0]       o,
                                                input logic [WIDTH-1:0] v,
                                                input logic [SHW:0]     amt);
    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH-1:0]   sra;
    dbl = {v, v} >> amt;
    sra = $unsigned($signed(v) >>> amt);
    case (o)
      OP_SLL:  return v << amt;
      OP_SRL:  return v >> amt;
      OP_SRA:  return sra;
      OP_ROR:  return dbl[WIDTH-1:0];
      default: return v;
    endcase
  endfunction

  // Bits moved this cycle: min(STEP, rem).
  always_comb begin
    k = ({1'b0, rem_q} < STEP_K) ? {1'b0, rem_q} : STEP_K;
  end

  // Next-state, datapath and status decode.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    result_d = result_q;
    rem_d    = rem_q;
    op_d     = op_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          result_d = bus.a;
          op_d     = bus.op;
          rem_d    = bus.shamt;
          state_d  = (bus.shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          result_d = shift_by(op_q, result_q, k);
          rem_d    = rem_q - k[SHW-1:0];
          if (rem_d == '0) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == SHIFT);
    valid_d = (state_d == DONE);
  end

  // State, datapath and status flops; status outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      rem_q    <= '0;
      op_q     <= OP_SLL;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops
      // update together from pre-edge values.
      state_q  <= state_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.ready  = ready_q;
  assign bus.busy   = busy_q;
  assign bus.valid  = valid_q;
  assign bus.result = result_q;

endmodule
